// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: op codes, FSM states and instruction layout shared by the ALU controller and the ALU
package alu_ctrl_pkg;
  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_NOT  = 3'd5,
    ALU_PASS = 3'd6,
    ALU_OUT  = 3'd7
  } op_e;
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, WB = 2'd2} state_e;
  typedef struct packed {
    op_e        op;
    logic [1:0] rd;
    logic [1:0] rs;
    logic       imm_sel;
    logic [7:0] imm;
  } instr_t;
endpackage

// File: rtl/alu_ctrl_if.sv
// alu_ctrl_if: instruction handshake and OUT result bus of the ALU controller
interface alu_ctrl_if #(parameter int DATA_W = 8);
  logic              instr_valid;
  logic              instr_ready;
  logic [15:0]       instr;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  modport master(output instr_valid, instr, input instr_ready, out_valid, out_data);
  modport slave(input instr_valid, instr, output instr_ready, out_valid, out_data);
endinterface

// File: rtl/alu_ctrl_regfile.sv
// alu_ctrl_regfile: register file, one sync write port, two comb read ports plus a debug read port
module alu_ctrl_regfile #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [1:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        raddr_a,
  input  logic [1:0]        raddr_b,
  input  logic [1:0]        dbg_addr,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic [DATA_W-1:0] dbg_data
);
  logic [DATA_W-1:0] r [NREGS];
  always_ff @(posedge clk)
    if (rst) for (int i = 0; i < NREGS; i++) r[i] <= '0;
    else if (we) r[waddr] <= wdata;
  assign rdata_a  = r[raddr_a];
  assign rdata_b  = r[raddr_b];
  assign dbg_data = r[dbg_addr];
endmodule

// File: rtl/alu_ctrl.sv
// alu_ctrl: IDLE/EXEC/WB sequencer driving an external ALU; ALU_CTRL_FLAGS_EN adds zero/negative flags
module alu_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NREGS  = 4
) (
  input  logic              clk,
  input  logic              rst,
  alu_ctrl_if.slave         bus,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_out,
  output logic              busy,
  input  logic [1:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
`ifdef ALU_CTRL_FLAGS_EN
  ,
  output logic              flag_z,
  output logic              flag_n
`endif
);
  state_e            state;
  instr_t            ins;
  logic [1:0]        rd;
  logic [DATA_W-1:0] result, ra_data, rb_data;
  logic              we;
  assign ins             = instr_t'(bus.instr);
  assign bus.instr_ready = state == IDLE && !rst;
  assign busy            = state != IDLE;
  assign we              = state == WB && alu_op != ALU_OUT;
  alu_ctrl_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_rf (
    .clk,
    .rst,
    .we,
    .waddr   (rd),
    .wdata   (result),
    .raddr_a (ins.rd),
    .raddr_b (ins.rs),
    .dbg_addr,
    .rdata_a (ra_data),
    .rdata_b (rb_data),
    .dbg_data
  );
  // OUT raises out_valid at the EXEC edge so the pulse and its data occupy the WB cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rd            <= '0;
      result        <= '0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_op        <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
`ifdef ALU_CTRL_FLAGS_EN
      flag_z        <= 1'b0;
      flag_n        <= 1'b0;
`endif
    end else begin
      bus.out_valid <= 1'b0;
      case (state)
        IDLE: if (bus.instr_valid) begin
          alu_op <= ins.op;
          alu_a  <= ra_data;
          alu_b  <= ins.imm_sel ? ins.imm : rb_data;
          rd     <= ins.rd;
          state  <= EXEC;
        end
        EXEC: begin
          result        <= alu_out;
          bus.out_valid <= alu_op == ALU_OUT;
          if (alu_op == ALU_OUT) bus.out_data <= alu_a;
          state         <= WB;
        end
        WB: begin
`ifdef ALU_CTRL_FLAGS_EN
          if (alu_op != ALU_OUT) begin
            flag_z <= result == '0;
            flag_n <= result[DATA_W-1];
          end
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl: randomized self-checking bench for alu_ctrl against a register-array reference model
module tb_alu_ctrl;
  logic       clk = 0, rst = 1;
  logic [7:0] alu_a, alu_b, alu_out, dbg_data;
  logic [2:0] alu_op;
  logic       busy;
  logic [1:0] dbg_addr = 0;
  int         tests = 0, fails = 0, cyc = 0, acc = 0, prev = 0;
  logic [7:0] m [4];
  logic       mz = 0, mn = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  alu_ctrl_if bus ();
`ifdef ALU_CTRL_FLAGS_EN
  logic flag_z, flag_n;
`endif
  alu_ctrl dut (
    .clk, .rst, .bus, .alu_a, .alu_b, .alu_op, .alu_out, .busy, .dbg_addr, .dbg_data
`ifdef ALU_CTRL_FLAGS_EN
    , .flag_z, .flag_n
`endif
  );
  function automatic logic [7:0] ref_alu(input logic [2:0] op, input logic [7:0] a, b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ~a;
      3'd6: return b;
      default: return a;
    endcase
  endfunction
  assign alu_out = ref_alu(alu_op, alu_a, alu_b);
  task automatic check(input string tag, input logic [31:0] got, exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic check_flags();
`ifdef ALU_CTRL_FLAGS_EN
    check("flag_z", flag_z, mz);
    check("flag_n", flag_n, mn);
`endif
  endtask
  task automatic run(input logic [2:0] op, input logic [1:0] rd, rs, input logic isel,
                     input logic [7:0] imm, output int a_cyc);
    logic [7:0] ea, eb, res;
    int t = 0;
    bus.instr_valid = 1;
    bus.instr = {op, rd, rs, isel, imm};
    while (!bus.instr_ready && t < 8) begin
      @(negedge clk);
      t++;
    end
    check("accept_wait", t < 8, 1);
    ea  = m[rd];
    eb  = isel ? imm : m[rs];
    res = ref_alu(op, ea, eb);
    @(posedge clk);
    #1 a_cyc = cyc;
    bus.instr = 16'($urandom);
    @(negedge clk);
    check("exec_ready", bus.instr_ready, 0);
    check("exec_busy", busy, 1);
    check("alu_op", alu_op, op);
    check("alu_a", alu_a, ea);
    check("alu_b", alu_b, eb);
    check("exec_out_valid", bus.out_valid, 0);
    @(negedge clk);
    check("wb_ready", bus.instr_ready, 0);
    check("wb_out_valid", bus.out_valid, op == 3'd7);
    if (op == 3'd7) check("out_data", bus.out_data, ea);
    else begin
      m[rd] = res;
      mz = res == 0;
      mn = res[7];
    end
    dbg_addr = rd;
    @(negedge clk);
    bus.instr_valid = 0;
    check("idle_ready", bus.instr_ready, 1);
    check("idle_busy", busy, 0);
    check("idle_out_valid", bus.out_valid, 0);
    check("dbg_rd", dbg_data, m[rd]);
    check_flags();
  endtask
  initial begin
    bus.instr_valid = 0;
    bus.instr = 0;
    for (int i = 0; i < 4; i++) m[i] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", bus.instr_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check_flags();
    rst = 0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1 check("rst_reg", dbg_data, 0);
    end
    run(3'd6, 2'd1, 2'd0, 1, 8'h5A, acc);
    run(3'd6, 2'd0, 2'd0, 1, 8'hFF, acc);
    run(3'd6, 2'd1, 2'd0, 1, 8'h01, acc);
    run(3'd0, 2'd0, 2'd1, 0, 8'h77, acc);
    run(3'd6, 2'd2, 2'd0, 1, 8'h00, acc);
    run(3'd1, 2'd2, 2'd0, 1, 8'h01, acc);
    run(3'd5, 2'd2, 2'd0, 0, 8'h00, acc);
    run(3'd6, 2'd3, 2'd0, 1, 8'hC3, acc);
    run(3'd7, 2'd3, 2'd0, 0, 8'h00, acc);
    run(3'd0, 2'd1, 2'd1, 0, 8'h00, acc);
    run(3'd6, 2'd0, 2'd0, 1, 8'h11, prev);
    run(3'd4, 2'd0, 2'd3, 0, 8'h00, acc);
    check("b2b_spacing", acc - prev, 3);
    prev = acc;
    run(3'd2, 2'd3, 2'd1, 1, 8'hF0, acc);
    check("b2b_spacing", acc - prev, 3);
    prev = acc;
    run(3'd3, 2'd2, 2'd0, 0, 8'h00, acc);
    check("b2b_spacing", acc - prev, 3);
    bus.instr_valid = 1;
    bus.instr = {3'd0, 2'd0, 2'd0, 1'b1, 8'h33};
    @(posedge clk);
    #1 bus.instr_valid = 0;
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 4; i++) m[i] = 0;
    mz = 0;
    mn = 0;
    dbg_addr = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_out_valid", bus.out_valid, 0);
      check("midrst_r0", dbg_data, 0);
      check("midrst_busy", busy, 0);
    end
    check_flags();
    run(3'd6, 2'd0, 2'd0, 1, 8'h42, acc);
    for (int k = 0; k < 40; k++)
      run(3'($urandom_range(0, 7)), 2'($urandom), 2'($urandom), 1'($urandom), 8'($urandom), acc);
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1 check("final_reg", dbg_data, m[i]);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
